// File: rtl/seg_display_ctrl_pkg.sv
// seg_display_ctrl_pkg: register map, CTRL layout and segment patterns for the 7-segment controller
package seg_display_ctrl_pkg;
  localparam logic [31:0] OFF_DATA = 32'h0;
  localparam logic [31:0] OFF_CTRL = 32'h4;
  localparam int CTRL_EN = 0;
  localparam int CTRL_BLZ = 1;
  localparam int CTRL_MASK_LSB = 8;
  localparam logic [31:0] CTRL_RST = 32'h0000_FF01;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: CPU data-bus slave port of the display controller
interface seg_display_ctrl_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output sel, we, addr, wdata, input rdata);
  modport slave (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/seg_display_ctrl_hex_decode.sv
// seg_hex_decode: 4-bit hex nibble to active-low g..a segment pattern
module seg_hex_decode
  import seg_display_ctrl_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_LUT[i_nib];
endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: memory-mapped 8-digit multiplexed 7-segment display controller
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int          SCAN_DIV  = 50000,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  seg_display_ctrl_if.slave        bus,
  output logic [7:0]               dig_en,
  output logic [7:0]               seg
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] P_TC = PW'(SCAN_DIV - 1);
  localparam logic [31:0] A_DATA = BASE_ADDR + OFF_DATA;
  localparam logic [31:0] A_CTRL = BASE_ADDR + OFF_CTRL;

  logic [31:0]   r_data;
  logic          r_en;
  logic          r_blz;
  logic [7:0]    r_mask;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [7:0]    r_dig_en;
  logic [7:0]    r_seg;
  logic          w_hit_data;
  logic          w_hit_ctrl;
  logic [31:0]   w_ctrl;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg7;
  logic          w_hi_zero;
  logic          w_blank;
  logic          w_unused;

  assign w_hit_data = bus.sel && bus.addr[31:2] == A_DATA[31:2];
  assign w_hit_ctrl = bus.sel && bus.addr[31:2] == A_CTRL[31:2];
  assign w_ctrl     = {16'h0, r_mask, 6'h0, r_blz, r_en};
  assign bus.rdata  = w_hit_data ? r_data : w_hit_ctrl ? w_ctrl : 32'h0;
  assign w_unused   = ^{bus.addr[1:0], bus.wdata[31:16], bus.wdata[7:2]};

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_data <= 32'h0;
      r_en   <= CTRL_RST[CTRL_EN];
      r_blz  <= CTRL_RST[CTRL_BLZ];
      r_mask <= CTRL_RST[CTRL_MASK_LSB +: 8];
    end else begin
      if (bus.we && w_hit_data) r_data <= bus.wdata;
      if (bus.we && w_hit_ctrl) begin
        r_en   <= bus.wdata[CTRL_EN];
        r_blz  <= bus.wdata[CTRL_BLZ];
        r_mask <= bus.wdata[CTRL_MASK_LSB +: 8];
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else if (!r_en) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else if (r_presc == P_TC) begin
      r_presc <= '0;
      r_idx   <= r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Leading-zero test: everything from the current nibble upward must be zero
  assign w_nib     = r_data[{r_idx, 2'b00} +: 4];
  assign w_hi_zero = (r_data >> {r_idx, 2'b00}) == 32'h0;
  assign w_blank   = !r_mask[r_idx] || (r_blz && r_idx != 3'd0 && w_hi_zero);

  seg_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg7)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_dig_en <= 8'hFF;
      r_seg    <= 8'hFF;
    end else begin
      r_dig_en <= (r_en && !w_blank) ? ~(8'b1 << r_idx) : 8'hFF;
      r_seg    <= r_en ? {1'b1, w_seg7} : 8'hFF;
    end
  end

  assign dig_en = r_dig_en;
  assign seg    = r_seg;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: scoreboard bench for the 7-segment controller with SCAN_DIV=4
module tb_seg_display_ctrl;
  import seg_display_ctrl_pkg::*;
  localparam logic [31:0] A_D = 32'hFFFF_F000;
  localparam logic [31:0] A_C = 32'hFFFF_F004;

  typedef struct {
    logic        co;
    logic [7:0]  ed;
    logic [7:0]  es;
    logic        cr;
    logic [31:0] er;
    string       nm;
  } exp_t;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst = 1'b1;
  logic [7:0] dig_en;
  logic [7:0] seg;
  exp_t       q[$];
  int         n_run = 0;
  int         n_fail = 0;

  seg_display_ctrl_if bus();

  seg_display_ctrl #(.SCAN_DIV(4), .BASE_ADDR(A_D)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus),
    .dig_en  (dig_en),
    .seg     (seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Drive one cycle of bus activity and queue what the DUT must show at the following negedge
  task automatic step(input logic r, input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic co, input logic [7:0] ed,
                      input logic [7:0] es, input logic cr, input logic [31:0] er,
                      input string nm);
    @(posedge cpu_clk);
    #1;
    cpu_rst   = r;
    bus.sel   = s;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    q.push_back('{co, ed, es, cr, er, nm});
  endtask

  task automatic run_scan(input logic [31:0] ctrl, input logic [31:0] data,
                          input logic [63:0] dig, input logic [63:0] sg, input string nm);
    int dg;
    step(0, 1, 1, A_C, 32'h0, 0, 8'h0, 8'h0, 0, 32'h0, nm);
    step(0, 1, 1, A_D, data, 0, 8'h0, 8'h0, 0, 32'h0, nm);
    step(0, 1, 1, A_C, ctrl, 1, 8'hFF, 8'hFF, 0, 32'h0, {nm, "_stopped"});
    step(0, 1, 0, A_D, 32'h0, 1, 8'hFF, 8'hFF, 1, data, {nm, "_rd_data"});
    for (int i = 0; i < 36; i++) begin
      dg = (i / 4) % 8;
      case (i)
        1: step(0, 1, 0, A_C, 32'h0, 1, dig[dg*8 +: 8], sg[dg*8 +: 8], 1, ctrl & 32'h0000_FF03, {nm, "_rd_ctrl"});
        2: step(0, 1, 0, A_D + 32'd8, 32'h0, 1, dig[dg*8 +: 8], sg[dg*8 +: 8], 1, 32'h0, {nm, "_rd_unmapped"});
        3: step(0, 0, 1, A_D, ~data, 1, dig[dg*8 +: 8], sg[dg*8 +: 8], 1, 32'h0, {nm, "_wr_nosel"});
        5: step(0, 1, 0, A_D, 32'h0, 1, dig[dg*8 +: 8], sg[dg*8 +: 8], 1, data, {nm, "_rd_data2"});
        default: step(0, 0, 0, 32'h0, 32'h0, 1, dig[dg*8 +: 8], sg[dg*8 +: 8], 1, 32'h0, {nm, "_scan"});
      endcase
    end
  endtask

  always @(negedge cpu_clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.co) begin
        n_run++;
        if (dig_en !== e.ed || seg !== e.es) begin
          n_fail++;
          $display("FAIL %s out: dig_en=%h seg=%h expected dig_en=%h seg=%h", e.nm, dig_en, seg, e.ed, e.es);
        end
      end
      if (e.cr) begin
        n_run++;
        if (bus.rdata !== e.er) begin
          n_fail++;
          $display("FAIL %s rdata: got %h expected %h", e.nm, bus.rdata, e.er);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.addr = 32'h0;
    bus.wdata = 32'h0;
    step(1, 1, 0, A_C, 32'h0, 1, 8'hFF, 8'hFF, 1, 32'h0000_FF01, "rst_ctrl");
    step(1, 1, 0, A_D, 32'h0, 1, 8'hFF, 8'hFF, 1, 32'h0, "rst_data");
    step(1, 1, 0, A_C | 32'h3, 32'h0, 1, 8'hFF, 8'hFF, 1, 32'h0000_FF01, "rst_addr_lsb");
    run_scan(32'hA5A5_FF01, 32'h1234_5678, 64'h7FBF_DFEF_F7FB_FDFE, 64'hF9A4_B099_9282_F880, "hex");
    step(0, 1, 1, A_C, 32'h0, 1, 8'hFD, 8'hF8, 0, 32'h0, "mid_wr");
    step(0, 0, 0, 32'h0, 32'h0, 1, 8'hFD, 8'hF8, 0, 32'h0, "mid_hold");
    step(0, 1, 1, A_C, 32'h0000_FF01, 1, 8'hFF, 8'hFF, 1, 32'h0, "mid_off");
    step(0, 0, 0, 32'h0, 32'h0, 1, 8'hFF, 8'hFF, 0, 32'h0, "reen_wait");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 32'h0, 32'h0, 1, i < 4 ? 8'hFE : 8'hFD, i < 4 ? 8'h80 : 8'hF8, 0, 32'h0, "reen_scan");
    step(1, 1, 0, A_D, 32'h0, 1, 8'hFF, 8'hFF, 1, 32'h0, "rst_async");
    step(1, 0, 0, 32'h0, 32'h0, 1, 8'hFF, 8'hFF, 0, 32'h0, "rst_hold");
    step(0, 0, 0, 32'h0, 32'h0, 1, 8'hFF, 8'hFF, 0, 32'h0, "rst_release");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 32'h0, 32'h0, 1, i < 4 ? 8'hFE : 8'hFD, 8'hC0, 0, 32'h0, "rst_restart");
    run_scan(32'h0000_FF03, 32'h0000_00A5, 64'hFFFF_FFFF_FFFF_FDFE, 64'hC0C0_C0C0_C0C0_8892, "blz_a5");
    run_scan(32'h0000_FF03, 32'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hC0C0_C0C0_C0C0_C0C0, "blz_zero");
    run_scan(32'h0000_0F01, 32'h1234_5678, 64'hFFFF_FFFF_F7FB_FDFE, 64'hF9A4_B099_9282_F880, "mask");
    run_scan(32'h0000_FF03, 32'h0010_2000, 64'hFFFF_DFEF_F7FB_FDFE, 64'hC0C0_F9C0_A4C0_C0C0, "blz_inner");
    repeat (3) @(posedge cpu_clk);
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
